ask_tx_controller: RTL and testbench

- Frame sequencer for the ASK transmit path. It sits between the host control logic and the modulator (LFSR -> word generator -> word XOR).
- On a start command it seeds the LFSR through the modulator's load input and emits a fixed preamble.
- It then forwards modulator output bits for a programmed number of 12-bit words, appends a guard interval, and keys a square-wave carrier with the resulting bit stream (on-off keying).

---
 rtl/ask_tx_controller.sv | 125 ++++++++++++
 tb/tb_ask_tx_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ask_tx_controller.sv
// ask_tx_controller: ASK frame sequencer that seeds the modulator, sends preamble, payload and guard bits,
// and on-off keys a square-wave carrier with the resulting baseband stream.
module ask_tx_controller #(
    parameter logic [7:0] PREAMBLE     = 8'b1010_1011,
    parameter int         SEED_CYCLES  = 2,
    parameter int         GUARD_CYCLES = 12,
    parameter int         CARRIER_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] frame_words,
    input  logic       new_word,
    input  logic       result_out,
    output logic       mod_load,
    output logic       tx_bit,
    output logic       tx_en,
    output logic       ask_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] words_sent
);
    localparam logic [7:0] SEED_LAST  = 8'(SEED_CYCLES - 1);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0] CAR_LAST   = 8'(CARRIER_HALF - 1);

    typedef enum logic [2:0] {IDLE, SEED, PRE, PAYLOAD, GUARD, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, len_q, len_d, words_q, words_d, car_cnt_q, car_cnt_d;
    logic       car_q, car_d, tx_bit_d, wrap, car_hold, abortable;
    logic       mod_load_q, tx_bit_q, tx_en_q, ask_q, busy_q, done_q;

    assign abortable = state_q inside {SEED, PRE, PAYLOAD};
    assign wrap      = car_cnt_q == CAR_LAST;
    // carrier is parked at phase 0 through IDLE so every frame starts on the same phase
    assign car_hold  = state_q == IDLE || state_d == IDLE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        len_d   = len_q;
        words_d = words_q;
        if (abortable && abort) begin
            state_d = GUARD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = SEED;
                        len_d   = frame_words;
                        words_d = '0;
                    end
                end
                SEED: if (cnt_q == SEED_LAST) begin
                    state_d = PRE;
                    cnt_d   = '0;
                end
                PRE: if (cnt_q == 8'd7) begin
                    state_d = (len_q == 8'd0) ? GUARD : PAYLOAD;
                    cnt_d   = '0;
                end
                PAYLOAD: begin
                    cnt_d = '0;
                    if (new_word) begin
                        words_d = words_q + 8'd1;
                        if (words_d == len_q) state_d = GUARD;
                    end
                end
                GUARD: if (cnt_q == GUARD_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        car_cnt_d = (car_hold || wrap) ? 8'd0 : car_cnt_q + 8'd1;
        car_d     = car_hold ? 1'b0 : car_q ^ wrap;
        tx_bit_d  = (state_d == PRE) ? PREAMBLE[3'd7 - cnt_d[2:0]] : (state_d == PAYLOAD) & result_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            words_q    <= '0;
            car_cnt_q  <= '0;
            car_q      <= 1'b0;
            mod_load_q <= 1'b0;
            tx_bit_q   <= 1'b0;
            tx_en_q    <= 1'b0;
            ask_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            words_q    <= words_d;
            car_cnt_q  <= car_cnt_d;
            car_q      <= car_d;
            mod_load_q <= state_d == SEED;
            tx_bit_q   <= tx_bit_d;
            tx_en_q    <= state_d inside {PRE, PAYLOAD};
            ask_q      <= tx_bit_d & car_d;
            busy_q     <= state_d != IDLE;
            done_q     <= state_d == DONE;
        end
    end

    assign mod_load   = mod_load_q;
    assign tx_bit     = tx_bit_q;
    assign tx_en      = tx_en_q;
    assign ask_out    = ask_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign words_sent = words_q;
endmodule

// File: tb/tb_ask_tx_controller.sv
// tb_ask_tx_controller: randomized frames against a frame-timeline reference model, checked through
// a per-cycle output scoreboard plus a done-event scoreboard of final word counts.
module tb_ask_tx_controller;
    localparam int S = 2, G = 12, CH = 4, MAXT = 256;

    typedef struct packed {
        logic       mod_load, tx_bit, tx_en, ask_out, busy, done;
        logic [7:0] words;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, new_word = 1'b0, result_out = 1'b0;
    logic [7:0] frame_words = '0, words_sent;
    logic       mod_load, tx_bit, tx_en, ask_out, busy, done;
    logic [7:0] pre_v = 8'b1010_1011;
    logic [7:0] last_words = '0;
    bit         nw_a[MAXT], ab_a[MAXT], ro_a[MAXT];
    exp_t       exp_q[$];
    logic [7:0] done_q[$];
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    ask_tx_controller dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_words(frame_words),
        .new_word(new_word), .result_out(result_out), .mod_load(mod_load), .tx_bit(tx_bit),
        .tx_en(tx_en), .ask_out(ask_out), .busy(busy), .done(done), .words_sent(words_sent)
    );

    always @(posedge clk) begin
        exp_t       e, a;
        logic [7:0] w;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {mod_load, tx_bit, tx_en, ask_out, busy, done, words_sent};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got ml=%b bit=%b en=%b ask=%b busy=%b done=%b ws=%0d, want ml=%b bit=%b en=%b ask=%b busy=%b done=%b ws=%0d",
                         $time, a.mod_load, a.tx_bit, a.tx_en, a.ask_out, a.busy, a.done, a.words,
                         e.mod_load, e.tx_bit, e.tx_en, e.ask_out, e.busy, e.done, e.words);
            end
        end
        if (done === 1'b1) begin
            n_chk++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done @%0t: got done=1, want no frame completion", $time);
            end else begin
                w = done_q.pop_front();
                if (words_sent !== w) begin
                    n_fail++;
                    $display("FAIL done_words @%0t: got %0d, want %0d", $time, words_sent, w);
                end
            end
        end
    end

    // expected outputs t cycles after the start edge, for a frame whose guard begins at cycle gs
    function automatic exp_t exp_at(int t, int gs);
        exp_t e;
        int   w = 0;
        e = '0;
        for (int u = S + 8; u < t && u < gs; u++) if (nw_a[u] && !ab_a[u]) w++;
        e.words    = 8'(w);
        e.mod_load = t < S && t < gs;
        e.tx_en    = t >= S && t < gs;
        if (e.tx_en) e.tx_bit = (t < S + 8) ? pre_v[7 - (t - S)] : ro_a[t - 1];
        e.ask_out  = e.tx_bit & ((t / CH) % 2 == 1);
        e.busy     = t <= gs + G;
        e.done     = t == gs + G;
        return e;
    endfunction

    task automatic cyc(input bit st, input bit ab, input bit nw, input bit ro, input bit rs, input exp_t e);
        start = st; abort = ab; new_word = nw; result_out = ro; rst = rs;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        exp_t e;
        e = '0;
        e.words = last_words;
        for (int i = 0; i < n; i++) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, e);
    endtask

    task automatic run_frame(input int len, input int period, input int abort_word, input int abort_at,
                             input int rst_word, input bit force_one, input bit hold, input bit start_abort);
        int   gs, cnt, k, rst_t, end_t;
        exp_t e, fin;
        for (int u = 0; u < MAXT; u++) begin
            if (u < S + 8) nw_a[u] = 1'($urandom);
            else if (period > 0) nw_a[u] = ((u - S - 8) % period) == period - 1;
            else nw_a[u] = u > 150 || $urandom_range(0, 3) == 0;
            ro_a[u] = force_one ? 1'b1 : 1'($urandom);
            ab_a[u] = u == abort_at;
        end
        rst_t = -1;
        k = 0;
        for (int u = S + 8; u < MAXT; u++) if (nw_a[u]) begin
            k++;
            if (k == abort_word) ab_a[u] = 1'b1;
            if (k == rst_word) rst_t = u + 1;
        end
        gs = -1;
        cnt = 0;
        for (int u = 0; u < MAXT && gs < 0; u++) begin
            if (ab_a[u]) gs = u + 1;
            else if (u == S + 7 && len == 0) gs = u + 1;
            else if (u >= S + 8 && nw_a[u]) begin
                cnt++;
                if (cnt == len) gs = u + 1;
            end
        end
        end_t = (rst_t >= 0) ? rst_t + 1 : gs + G + 1;
        fin = exp_at(gs + G, gs);
        if (rst_t < 0) done_q.push_back(fin.words);
        frame_words = 8'(len);
        cyc(1, start_abort, 1'($urandom), 1'($urandom), 0, exp_at(0, gs));
        frame_words = 8'($urandom);
        for (int t = 0; t < end_t; t++) begin
            e = (t == rst_t) ? exp_t'('0) : exp_at(t + 1, gs);
            cyc(hold, ab_a[t], nw_a[t], ro_a[t], t == rst_t, e);
        end
        last_words = (rst_t >= 0) ? 8'd0 : fin.words;
    endtask

    initial begin
        @(negedge clk);
        cyc(0, 0, 0, 0, 1, '0);
        cyc(0, 0, 0, 0, 1, '0);
        idle(2);
        run_frame(3, 0, 0, -1, 0, 0, 0, 1);
        idle(1);
        run_frame(0, 0, 0, -1, 0, 0, 0, 0);
        idle(2);
        run_frame(2, 12, 0, -1, 0, 1, 0, 0);
        idle(1);
        run_frame(5, 0, 2, -1, 0, 0, 0, 0);
        idle(1);
        run_frame(4, 0, 0, -1, 2, 0, 0, 0);
        idle(1);
        run_frame(3, 0, 0, -1, 0, 0, 0, 0);
        run_frame(1, 0, 0, -1, 0, 0, 1, 0);
        run_frame(1, 0, 0, -1, 0, 0, 1, 0);
        idle(2);
        run_frame(3, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        run_frame(3, 0, 0, S + 3, 0, 1, 0, 0);
        idle(1);
        for (int i = 0; i < 8; i++) begin
            run_frame($urandom_range(0, 6), 0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 4) == 0) ? $urandom_range(0, S + 7) : -1, 0, 0, 0, 1'($urandom));
            idle($urandom_range(0, 2));
        end
        idle(2);
        n_chk++;
        if (done_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_done: got %0d frames without done, want 0", done_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
